// File: rtl/uart_frame_packetizer.sv
// uart_frame_packetizer: FIFO-buffered UART transmitter wrapping bytes into SOF/LEN/payload/CSUM frames
module uart_frame_packetizer #(
  parameter int         CLK_FREQ    = 50000000,
  parameter int         BAUD_RATE   = 9600,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         MAX_PAYLOAD = 8,
  parameter int         PARITY_EN   = 1,
  parameter int         PARITY_ODD  = 0,
  parameter int         STOP_BITS   = 1,
  parameter logic [7:0] SOF_BYTE    = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       flush,
  input  logic       tx_ready,
  output logic       serial_out,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       tx_busy,
  output logic       frame_done
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CTW = $clog2(CPB);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CTW-1:0] CLAST = CTW'(CPB - 1);
  localparam logic [3:0] BLAST = 4'(8 + PARITY_EN + STOP_BITS);
  localparam logic [CW-1:0] MAXC = CW'(MAX_PAYLOAD);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic PODD = PARITY_ODD != 0;
  typedef enum logic [2:0] {IDLE, SOF, LEN, PAY, CSUM} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0] cur, len, csum, sent, head, launch_len;
  logic [3:0] bit_idx;
  logic [CTW-1:0] clk_cnt;
  logic flush_lat, wr, pop, launch, bit_end, byte_end;
  function automatic logic bit_val(input logic [7:0] d, input logic [3:0] i);
    return i == 4'd0 ? 1'b0 :
           i <= 4'd8 ? d[3'(i - 4'd1)] :
           (PARITY_EN != 0 && i == 4'd9) ? (^d) ^ PODD : 1'b1;
  endfunction
  assign fifo_full = count == DEPTH;
  assign fifo_empty = count == '0;
  assign wr = data_valid && !fifo_full;
  assign head = mem[rd_ptr];
  assign launch = state == IDLE && tx_ready && (count >= MAXC || (flush_lat && count != '0));
  assign launch_len = count >= MAXC ? 8'(MAX_PAYLOAD) : 8'(count);
  assign bit_end = state != IDLE && clk_cnt == CLAST;
  assign byte_end = bit_end && bit_idx == BLAST;
  // a pop happens exactly when the next byte slot is loaded with a payload byte
  assign pop = byte_end && (state == LEN || (state == PAY && sent != len));
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      flush_lat <= 1'b0;
      serial_out <= 1'b1;
      tx_busy <= 1'b0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
      cur <= '0;
      len <= '0;
      csum <= '0;
      sent <= '0;
      bit_idx <= '0;
      clk_cnt <= '0;
    end else begin
      overflow <= data_valid && fifo_full;
      frame_done <= 1'b0;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
      flush_lat <= (flush && !(state == IDLE && count == '0)) || (flush_lat && !launch);
      if (launch) begin
        state <= SOF;
        tx_busy <= 1'b1;
        serial_out <= 1'b0;
        cur <= SOF_BYTE;
        len <= launch_len;
        csum <= launch_len;
        sent <= '0;
        bit_idx <= '0;
        clk_cnt <= '0;
      end else if (state != IDLE) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
        if (byte_end) begin
          bit_idx <= '0;
          serial_out <= 1'b0;
          if (state == CSUM) begin
            state <= IDLE;
            tx_busy <= 1'b0;
            frame_done <= 1'b1;
            serial_out <= 1'b1;
          end else if (state == SOF) begin
            state <= LEN;
            cur <= len;
          end else if (pop) begin
            state <= PAY;
            cur <= head;
            csum <= csum ^ head;
            sent <= sent + 8'd1;
          end else begin
            state <= CSUM;
            cur <= csum;
          end
        end else if (bit_end) begin
          bit_idx <= bit_idx + 4'd1;
          serial_out <= bit_val(cur, bit_idx + 4'd1);
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_packetizer.sv
// tb_uart_frame_packetizer: directed checks of framing, FIFO limits, launch timing and reset abort
module tb_uart_frame_packetizer;
  logic clk = 0, rst = 1;
  logic [7:0] data_in = '0;
  logic data_valid = 0, flush = 0, tx_ready = 0, dv2 = 0, flush2 = 0, sel = 0;
  logic so1, so2, full1, full2, empty1, empty2, ovf1, ovf2, busy1, busy2, fd1, fd2;
  logic rx_line, busy, fd;
  logic [7:0] ex[$];
  int n_cmp = 0, n_err = 0, fd_cnt = 0, w;
  assign rx_line = sel ? so2 : so1;
  assign busy = sel ? busy2 : busy1;
  assign fd = sel ? fd2 : fd1;
  always #5 clk = ~clk;
  always @(negedge clk) if (fd) fd_cnt++;
  uart_frame_packetizer #(.CLK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(16), .MAX_PAYLOAD(8),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .SOF_BYTE(8'h7E)) u1 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .flush(flush),
    .tx_ready(tx_ready), .serial_out(so1), .fifo_full(full1), .fifo_empty(empty1),
    .overflow(ovf1), .tx_busy(busy1), .frame_done(fd1));
  uart_frame_packetizer #(.CLK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(16), .MAX_PAYLOAD(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .SOF_BYTE(8'h7E)) u2 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(dv2), .flush(flush2),
    .tx_ready(tx_ready), .serial_out(so2), .fifo_full(full2), .fifo_empty(empty2),
    .overflow(ovf2), .tx_busy(busy2), .frame_done(fd2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] d);
    data_in = d;
    if (sel) dv2 = 1; else data_valid = 1;
    sync();
    dv2 = 0;
    data_valid = 0;
  endtask
  task automatic pulse_flush();
    if (sel) flush2 = 1; else flush = 1;
    sync();
    flush = 0;
    flush2 = 0;
  endtask
  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rx_line !== 1'b0 && n < 300);
    check("start_seen", rx_line, 0);
  endtask
  function automatic logic [11:0] exp_vec(input logic [7:0] d, input int pe, input int sb);
    logic [11:0] v = 12'h0;
    v[8:1] = d;
    if (pe != 0) begin
      v[9] = ^d;
      v[10] = 1'b1;
      if (sb == 2) v[11] = 1'b1;
    end else begin
      v[9] = 1'b1;
      if (sb == 2) v[10] = 1'b1;
    end
    return v;
  endfunction
  // entered at the negedge of the first start-bit cycle; samples every bit at its centre
  task automatic rx_frame(input int bpb, input int pe, input int sb);
    int t = 0, fd0 = fd_cnt, last;
    logic [11:0] g;
    for (int b = 0; b < ex.size(); b++) begin
      g = '0;
      for (int i = 0; i < bpb; i++) begin
        repeat (b * bpb * 10 + i * 10 + 5 - t) @(negedge clk);
        t = b * bpb * 10 + i * 10 + 5;
        g[i] = rx_line;
      end
      check($sformatf("byte%0d", b), g, exp_vec(ex[b], pe, sb));
    end
    last = ex.size() * bpb * 10 - 1;
    repeat (last - t) @(negedge clk);
    check("busy_last", busy, 1);
    check("fd_early", fd, 0);
    @(negedge clk);
    check("frame_done", fd, 1);
    check("busy_fall", busy, 0);
    check("line_idle", rx_line, 1);
    @(negedge clk);
    check("fd_pulses", fd_cnt - fd0, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_line", so1, 1);
    check("rst_busy", busy1, 0);
    check("rst_empty", empty1, 1);
    check("rst_full", full1, 0);
    check("rst_ovf", ovf1, 0);
    check("rst_fd", fd1, 0);
    check("rst_line2", so2, 1);
    sync();
    tx_ready = 1;
    foreach (ex[i]) ex.delete(i);
    wr(8'hA5); wr(8'h4A); wr(8'h94); wr(8'h56);
    repeat (5) @(negedge clk);
    check("no_launch_wo_flush", busy1, 0);
    check("not_empty", empty1, 0);
    sync();
    pulse_flush();
    wait_start(w);
    check("flush_latency", w, 2);
    check("busy_rise", busy1, 1);
    ex = '{8'h7E, 8'h04, 8'hA5, 8'h4A, 8'h94, 8'h56, 8'h29};
    rx_frame(11, 1, 1);
    check("empty_after_f1", empty1, 1);
    sync();
    for (int i = 0; i < 9; i++) wr(8'(i));
    wait_start(w);
    check("auto_latency", w, 1);
    ex = '{8'h7E, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    rx_frame(11, 1, 1);
    check("ninth_held", empty1, 0);
    repeat (5) @(negedge clk);
    check("ninth_no_launch", busy1, 0);
    sync();
    pulse_flush();
    wait_start(w);
    ex = '{8'h7E, 8'h01, 8'h08, 8'h09};
    rx_frame(11, 1, 1);
    sync();
    tx_ready = 0;
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
    check("full", full1, 1);
    check("full_not_empty", empty1, 0);
    wr(8'hEE);
    @(negedge clk);
    check("ovf_pulse", ovf1, 1);
    check("still_full", full1, 1);
    @(negedge clk);
    check("ovf_clear", ovf1, 0);
    repeat (30) @(negedge clk);
    check("held_busy", busy1, 0);
    check("held_line", so1, 1);
    sync();
    tx_ready = 1;
    @(negedge clk);
    check("ready_same_cycle", so1, 1);
    @(negedge clk);
    check("ready_start", so1, 0);
    check("ready_busy", busy1, 1);
    ex = '{8'h7E, 8'h08, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h08};
    fork
      rx_frame(11, 1, 1);
      begin
        repeat (50) @(posedge clk);
        #1 tx_ready = 0;
      end
    join
    repeat (20) @(negedge clk);
    check("no_relaunch", busy1, 0);
    check("half_full", full1, 0);
    sync();
    tx_ready = 1;
    wait_start(w);
    check("relaunch_latency", w, 2);
    ex = '{8'h7E, 8'h08, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h08};
    rx_frame(11, 1, 1);
    check("dropped_gone", empty1, 1);
    sel = 1;
    sync();
    wr(8'hFF);
    pulse_flush();
    wait_start(w);
    ex = '{8'h7E, 8'h01, 8'hFF, 8'hFE};
    rx_frame(11, 0, 2);
    sel = 0;
    sync();
    wr(8'h3C);
    pulse_flush();
    wait_start(w);
    sync();
    rst = 1;
    sync();
    rst = 0;
    @(negedge clk);
    check("abort_line", so1, 1);
    check("abort_busy", busy1, 0);
    check("abort_empty", empty1, 1);
    repeat (30) @(negedge clk);
    check("abort_stays_idle", so1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
